// File: rtl/sdram_cmd_issuer_if.sv
// Host request bus and decoder command bus of the SDRAM command issuer.
// The master side is the environment (host + controller ack); the slave side is the issuer.
interface sdram_cmd_issuer_if #(
    parameter int PADD_SIZE = 24,
    parameter int CMD_SIZE  = 3
);
    logic                 req_valid;
    logic                 req_ready;
    logic [CMD_SIZE-1:0]  req_cmd;
    logic [PADD_SIZE-1:0] req_addr;
    logic                 cmdack;
    logic [CMD_SIZE-1:0]  cmd;
    logic [PADD_SIZE-1:0] paddr;

    modport master (
        output req_valid, req_cmd, req_addr, cmdack,
        input  req_ready, cmd, paddr
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, cmdack,
        output req_ready, cmd, paddr
    );
endinterface

// File: rtl/sdram_cmd_issuer.sv
// SDRAM command issuer: request FIFO, power-up init sequence, hold-until-ack plus one NOP gap.
// Optional cmdack watchdog enabled by defining SDRAM_CMD_TIMEOUT_EN.
module sdram_cmd_issuer #(
    parameter int                   PADD_SIZE  = 24,
    parameter int                   CMD_SIZE   = 3,
    parameter int                   FIFO_AW    = 2,
    parameter logic [15:0]          INIT_WAIT  = 16'd200,
    parameter logic [PADD_SIZE-1:0] INIT_TIME  = '0,
    parameter logic [PADD_SIZE-1:0] INIT_RFCNT = '0,
    parameter logic [PADD_SIZE-1:0] INIT_MODE  = '0
`ifdef SDRAM_CMD_TIMEOUT_EN
    , parameter logic [7:0]         TIMEOUT    = 8'd64
`endif
) (
    input  logic               clk0,
    input  logic               reset,
    sdram_cmd_issuer_if.slave  bus,
    output logic               init_done,
    output logic               busy,
    output logic               err_timeout
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]    FULL_COUNT    = (FIFO_AW+1)'(DEPTH);
    localparam logic [CMD_SIZE-1:0] CMD_NOP       = CMD_SIZE'(3'b000);
    localparam logic [CMD_SIZE-1:0] CMD_PRECHARGE = CMD_SIZE'(3'b100);
    localparam logic [CMD_SIZE-1:0] CMD_LOAD_MOD  = CMD_SIZE'(3'b101);
    localparam logic [CMD_SIZE-1:0] CMD_LOAD_TIME = CMD_SIZE'(3'b110);
    localparam logic [CMD_SIZE-1:0] CMD_LOAD_RFC  = CMD_SIZE'(3'b111);

    typedef enum logic [2:0] {
        ST_INIT_WAIT,
        ST_INIT_CMD,
        ST_IDLE,
        ST_ISSUE,
        ST_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [CMD_SIZE-1:0]  cmd_q, cmd_d;
    logic [PADD_SIZE-1:0] paddr_q, paddr_d;
    logic [15:0]          waitCnt_q, waitCnt_d;
    logic [2:0]           initStep_q, initStep_d;
    logic                 initDone_q, initDone_d;
    logic                 errTimeout_q, errTimeout_d;
    logic [FIFO_AW-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [FIFO_AW:0]     count_q, count_d;

    logic [CMD_SIZE-1:0]  memCmd  [DEPTH];
    logic [PADD_SIZE-1:0] memAddr [DEPTH];

    logic                 reqReady, push, pop, timeoutHit;
    logic [CMD_SIZE-1:0]  initCmd;
    logic [PADD_SIZE-1:0] initAddr;

    // Slot availability comes from the registered count, so a same-cycle pop never frees a slot early.
    assign reqReady = initDone_q && (count_q != FULL_COUNT);
    assign push     = bus.req_valid && reqReady;

    assign bus.req_ready = reqReady;
    assign bus.cmd       = cmd_q;
    assign bus.paddr     = paddr_q;
    assign init_done     = initDone_q;
    assign err_timeout   = errTimeout_q;
    assign busy          = (state_q != ST_IDLE) || (count_q != '0);

    always_comb begin
        initCmd  = CMD_PRECHARGE;
        initAddr = '0;
        case (initStep_q)
            3'd1:    begin initCmd = CMD_LOAD_TIME; initAddr = INIT_TIME;  end
            3'd2:    begin initCmd = CMD_LOAD_RFC;  initAddr = INIT_RFCNT; end
            3'd3:    begin initCmd = CMD_LOAD_MOD;  initAddr = INIT_MODE;  end
            default: begin initCmd = CMD_PRECHARGE; initAddr = '0;         end
        endcase
    end

`ifdef SDRAM_CMD_TIMEOUT_EN
    logic [7:0] wdog_q;
    logic       holding;

    assign holding    = (state_q == ST_INIT_CMD) || ((state_q == ST_ISSUE) && (cmd_q != CMD_NOP));
    assign timeoutHit = holding && !bus.cmdack && (wdog_q == TIMEOUT - 8'd1);

    always_ff @(posedge clk0) begin
        if (reset || !holding || bus.cmdack || timeoutHit) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 8'd1;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        paddr_d      = paddr_q;
        waitCnt_d    = waitCnt_q;
        initStep_d   = initStep_q;
        initDone_d   = initDone_q;
        errTimeout_d = errTimeout_q;
        pop          = 1'b0;
        case (state_q)
            ST_INIT_WAIT: begin
                if (waitCnt_q == INIT_WAIT - 16'd1) begin
                    state_d = ST_INIT_CMD;
                    cmd_d   = CMD_PRECHARGE;
                    paddr_d = '0;
                end else begin
                    waitCnt_d = waitCnt_q + 16'd1;
                end
            end
            ST_INIT_CMD: begin
                // An abandoned init command still counts as done so the sequence cannot stall.
                if (bus.cmdack || timeoutHit) begin
                    state_d      = ST_GAP;
                    cmd_d        = CMD_NOP;
                    paddr_d      = '0;
                    initStep_d   = initStep_q + 3'd1;
                    errTimeout_d = errTimeout_q || timeoutHit;
                end
            end
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    cmd_d   = memCmd[rdPtr_q];
                    paddr_d = memAddr[rdPtr_q];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if ((cmd_q == CMD_NOP) || bus.cmdack || timeoutHit) begin
                    state_d      = ST_GAP;
                    cmd_d        = CMD_NOP;
                    paddr_d      = '0;
                    errTimeout_d = errTimeout_q || timeoutHit;
                end
            end
            ST_GAP: begin
                if (initDone_q) begin
                    state_d = ST_IDLE;
                end else if (initStep_q == 3'd4) begin
                    initDone_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_INIT_CMD;
                    cmd_d   = initCmd;
                    paddr_d = initAddr;
                end
            end
            default: state_d = ST_INIT_WAIT;
        endcase
    end

    always_comb begin
        wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk0) begin
        if (push) begin
            memCmd[wrPtr_q]  <= bus.req_cmd;
            memAddr[wrPtr_q] <= bus.req_addr;
        end
    end

    always_ff @(posedge clk0) begin
        if (reset) begin
            state_q      <= ST_INIT_WAIT;
            cmd_q        <= CMD_NOP;
            paddr_q      <= '0;
            waitCnt_q    <= '0;
            initStep_q   <= '0;
            initDone_q   <= 1'b0;
            errTimeout_q <= 1'b0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            paddr_q      <= paddr_d;
            waitCnt_q    <= waitCnt_d;
            initStep_q   <= initStep_d;
            initDone_q   <= initDone_d;
            errTimeout_q <= errTimeout_d;
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            count_q      <= count_d;
        end
    end
endmodule

// File: tb/tb_sdram_cmd_issuer.sv
// Directed testbench for sdram_cmd_issuer with a scoreboard of expected issued commands.
// Define SDRAM_CMD_TIMEOUT_EN to also exercise the watchdog.
module tb_sdram_cmd_issuer;
    localparam logic [15:0] INIT_WAIT_C  = 16'd200;
    localparam logic [23:0] INIT_TIME_C  = 24'h00_0A0B;
    localparam logic [23:0] INIT_RFCNT_C = 24'h00_0C0D;
    localparam logic [23:0] INIT_MODE_C  = 24'h00_0230;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [23:0] addr;
    } exp_t;

    logic clk0  = 1'b0;
    logic reset = 1'b1;
    logic initDone, busy, errTimeout;
    exp_t sbQ [$];
    int   nChecks = 0;
    int   nFails  = 0;

    logic [2:0]  initCmds  [4] = '{3'b100, 3'b110, 3'b111, 3'b101};
    logic [23:0] initAddrs [4] = '{24'h0, INIT_TIME_C, INIT_RFCNT_C, INIT_MODE_C};

    sdram_cmd_issuer_if #(.PADD_SIZE(24), .CMD_SIZE(3)) bus ();

    sdram_cmd_issuer #(
        .PADD_SIZE (24),
        .CMD_SIZE  (3),
        .FIFO_AW   (2),
        .INIT_WAIT (INIT_WAIT_C),
        .INIT_TIME (INIT_TIME_C),
        .INIT_RFCNT(INIT_RFCNT_C),
        .INIT_MODE (INIT_MODE_C)
    ) dut (
        .clk0       (clk0),
        .reset      (reset),
        .bus        (bus),
        .init_done  (initDone),
        .busy       (busy),
        .err_timeout(errTimeout)
    );

    always #5 clk0 = ~clk0;

    initial begin
        #300000;
        $display("[TB] FAIL globalTimeout: simulation did not finish");
        $fatal(1, "[TB] global time limit exceeded");
    end

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offers one request for a single edge; accepted requests are queued as expected issues.
    task automatic applyStimulus(input logic [2:0] c, input logic [23:0] a, input bit expectAccept);
        bus.req_valid = 1'b1;
        bus.req_cmd   = c;
        bus.req_addr  = a;
        step();
        bus.req_valid = 1'b0;
        if (expectAccept) sbQ.push_back('{cmd: c, addr: a});
    endtask

    task automatic expectIssue(input string tag, input int holdCycles, input int expWait, input bit doAck);
        int   waited;
        exp_t e;
        waited = 0;
        while (bus.cmd === 3'b000 && waited < 8) begin
            step();
            waited++;
        end
        e = (sbQ.size() > 0) ? sbQ.pop_front() : '0;
        if (expWait >= 0) checkOutput({tag, "Spacing"}, waited, expWait);
        checkOutput({tag, "Cmd"}, bus.cmd, e.cmd);
        checkOutput({tag, "Addr"}, bus.paddr, e.addr);
        for (int i = 0; i < holdCycles; i++) begin
            step();
            checkOutput({tag, "Held"}, bus.cmd, e.cmd);
        end
        if (doAck) begin
            bus.cmdack = 1'b1;
            step();
            bus.cmdack = 1'b0;
            checkOutput({tag, "GapCmd"}, bus.cmd, 3'b000);
            checkOutput({tag, "GapAddr"}, bus.paddr, 24'h0);
        end
    endtask

    // Expects to be entered one cycle after the reset edge, with reset already released.
    task automatic runInit();
        checkOutput("initReadyLow", bus.req_ready, 1'b0);
        for (int i = 1; i < int'(INIT_WAIT_C); i++) begin
            step();
            checkOutput("initWaitNop", bus.cmd, 3'b000);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            checkOutput("initCmd", bus.cmd, initCmds[k]);
            checkOutput("initAddr", bus.paddr, initAddrs[k]);
            step();
            checkOutput("initHeld", bus.cmd, initCmds[k]);
            bus.cmdack = 1'b1;
            step();
            bus.cmdack = 1'b0;
            checkOutput("initGapCmd", bus.cmd, 3'b000);
            checkOutput("initGapAddr", bus.paddr, 24'h0);
            checkOutput("initNotDone", initDone, 1'b0);
            step();
        end
        checkOutput("initDone", initDone, 1'b1);
        checkOutput("initIdleCmd", bus.cmd, 3'b000);
        checkOutput("initIdleBusy", busy, 1'b0);
        checkOutput("initReadyHigh", bus.req_ready, 1'b1);
    endtask

    initial begin
        exp_t e;
        bus.req_valid = 1'b0;
        bus.req_cmd   = 3'b000;
        bus.req_addr  = 24'h0;
        bus.cmdack    = 1'b0;

        // Reset state and power-up init sequence
        step();
        step();
        checkOutput("rstCmd", bus.cmd, 3'b000);
        checkOutput("rstAddr", bus.paddr, 24'h0);
        checkOutput("rstInitDone", initDone, 1'b0);
        checkOutput("rstErr", errTimeout, 1'b0);
        checkOutput("rstBusy", busy, 1'b1);
        reset = 1'b0;
        runInit();

        // Single READA, acked on the third hold edge
        applyStimulus(3'b001, 24'h12_3456, 1'b1);
        checkOutput("readaLatIdle", bus.cmd, 3'b000);
        checkOutput("readaBusy", busy, 1'b1);
        step();
        expectIssue("readA", 2, 0, 1'b1);
        step();
        checkOutput("readaIdleCmd", bus.cmd, 3'b000);
        checkOutput("readaIdleBusy", busy, 1'b0);

        // Blocker held without ack, then five back-to-back requests: four fit, fifth refused
        applyStimulus(3'b011, 24'h00_0ABC, 1'b1);
        step();
        applyStimulus(3'b001, 24'h10_0001, 1'b1);
        applyStimulus(3'b010, 24'h20_0002, 1'b1);
        applyStimulus(3'b100, 24'h30_0003, 1'b1);
        applyStimulus(3'b001, 24'h40_0004, 1'b1);
        checkOutput("fifoFullReady", bus.req_ready, 1'b0);
        checkOutput("fifoFullBusy", busy, 1'b1);
        applyStimulus(3'b010, 24'h50_0005, 1'b0);
        checkOutput("fifoStillFull", bus.req_ready, 1'b0);
        expectIssue("blocker", 1, 0, 1'b1);
        for (int i = 0; i < 4; i++) expectIssue("drain", 0, 2, 1'b1);
        step();
        step();
        checkOutput("noFifthCmd", bus.cmd, 3'b000);
        checkOutput("noFifthBusy", busy, 1'b0);

        // NOP needs no ack, lasts one cycle, then gap, then WRITEA
        applyStimulus(3'b000, 24'h00_0055, 1'b1);
        applyStimulus(3'b010, 24'h00_00FF, 1'b1);
        e = sbQ.pop_front();
        checkOutput("nopCmd", bus.cmd, e.cmd);
        checkOutput("nopAddr", bus.paddr, e.addr);
        step();
        checkOutput("nopGapCmd", bus.cmd, 3'b000);
        checkOutput("nopGapAddr", bus.paddr, 24'h0);
        expectIssue("writeA", 1, 2, 1'b0);

        // Reset mid-hold with a request still queued
        applyStimulus(3'b001, 24'h00_0777, 1'b0);
        checkOutput("preRstBusy", busy, 1'b1);
        reset = 1'b1;
        step();
        checkOutput("midRstCmd", bus.cmd, 3'b000);
        checkOutput("midRstAddr", bus.paddr, 24'h0);
        checkOutput("midRstInitDone", initDone, 1'b0);
        checkOutput("midRstReady", bus.req_ready, 1'b0);
        reset = 1'b0;
        sbQ.delete();
        runInit();
        step();
        step();
        checkOutput("postRstCmd", bus.cmd, 3'b000);
        checkOutput("postRstBusy", busy, 1'b0);

`ifdef SDRAM_CMD_TIMEOUT_EN
        // READA never acked is abandoned after 64 cycles; next entry then issues
        applyStimulus(3'b001, 24'h00_4321, 1'b1);
        applyStimulus(3'b100, 24'h00_0400, 1'b1);
        e = sbQ.pop_front();
        checkOutput("toCmd", bus.cmd, e.cmd);
        checkOutput("toAddr", bus.paddr, e.addr);
        for (int i = 1; i < 64; i++) step();
        checkOutput("toHeldCmd", bus.cmd, 3'b001);
        checkOutput("toNoErrYet", errTimeout, 1'b0);
        step();
        checkOutput("toErr", errTimeout, 1'b1);
        checkOutput("toAbandonCmd", bus.cmd, 3'b000);
        expectIssue("afterTo", 0, 2, 1'b1);
        checkOutput("toErrSticky", errTimeout, 1'b1);
`else
        checkOutput("errTiedLow", errTimeout, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
